// File: rtl/intr_pkg.sv
// Shared types and constants for the interrupt scheduler.
// FSM state encoding, source count, index width, vector layout.
package intr_pkg;

   localparam int NUM_IRQ = 8;
   localparam int IDX_W   = 3;
   localparam int VEC_N   = 16;

   localparam logic [VEC_N-1:0] VEC_BASE_D   = 16'h00F0;
   localparam logic [VEC_N-1:0] VEC_STRIDE_D = 16'h0002;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      REQ     = 2'd1,
      SERVICE = 2'd2
   } state_t;

endpackage

// File: rtl/intr_prio_enc.sv
// Fixed-priority encoder, lowest set index wins.
// Ports: req (NUM_IRQ) in; idx (IDX_W), valid out.
module intr_prio_enc
   import intr_pkg::*;
(
   input  logic [NUM_IRQ-1:0] req,
   output logic [IDX_W-1:0]   idx,
   output logic               valid
);

   // Scan high to low so the last hit is the lowest index.
   always_comb begin
      idx = '0;
      for (int i = NUM_IRQ - 1; i >= 0; i--) begin
         if (req[i]) idx = IDX_W'(i);
      end
   end

   assign valid = |req;

endmodule

// File: rtl/intr_scheduler.sv
// Interrupt scheduler: latch, mask, prioritise, offer to datapath.
// Clock/Reset(async low); Irq_req, Int_En, Mask_we/Mask_wdata,
// Inr_Ack, Inr_Done in; Inr_Check, Inr, Inr_Vector, Pending, Busy out.
// INTR_EDGE_EN: edge-detected pending (default build: level mode).
module intr_scheduler
   import intr_pkg::*;
#(
   parameter int               N          = VEC_N,
   parameter logic [N-1:0]     VEC_BASE   = N'(VEC_BASE_D),
   parameter logic [N-1:0]     VEC_STRIDE = N'(VEC_STRIDE_D)
) (
   input  logic               Clock,
   input  logic               Reset,
   input  logic [NUM_IRQ-1:0] Irq_req,
   input  logic               Int_En,
   input  logic               Mask_we,
   input  logic [NUM_IRQ-1:0] Mask_wdata,
   input  logic               Inr_Ack,
   input  logic               Inr_Done,
   output logic               Inr_Check,
   output logic [IDX_W-1:0]   Inr,
   output logic [N-1:0]       Inr_Vector,
   output logic [NUM_IRQ-1:0] Pending,
   output logic               Busy
);

   state_t state_q, state_d;

   logic [NUM_IRQ-1:0] irq_q;
   logic [NUM_IRQ-1:0] mask_q;
   logic [NUM_IRQ-1:0] pending_d;
   logic               en_q;
   logic               load_inr;
   logic               ack_take;
   logic [IDX_W-1:0]   enc_idx;
   logic               enc_valid;

   intr_prio_enc u_enc (
      .req   (Pending & mask_q),
      .idx   (enc_idx),
      .valid (enc_valid)
   );

   always_comb begin
      state_d  = state_q;
      load_inr = 1'b0;
      ack_take = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (en_q && enc_valid) begin
               state_d  = REQ;
               load_inr = 1'b1;
            end
         end
         REQ: begin
            // Ack wins over a same-cycle Done.
            if (Inr_Ack) begin
               state_d  = SERVICE;
               ack_take = 1'b1;
            end
         end
         SERVICE: begin
            if (Inr_Done) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

`ifdef INTR_EDGE_EN
   logic [NUM_IRQ-1:0] irq_prev;
   logic [NUM_IRQ-1:0] rise;
   logic [NUM_IRQ-1:0] clr;

   assign rise = irq_q & ~irq_prev;
   assign clr  = ack_take ? (NUM_IRQ'(1) << Inr) : '0;

   // Rise is OR'd after the clear so a same-cycle set survives.
   assign pending_d = (Pending & ~clr) | rise;

   always_ff @(posedge Clock or negedge Reset) begin
      if (!Reset) irq_prev <= '0;
      else        irq_prev <= irq_q;
   end
`else
   assign pending_d = irq_q;
`endif

   always_ff @(posedge Clock or negedge Reset) begin
      if (!Reset) begin
         state_q <= IDLE;
         irq_q   <= '0;
         Pending <= '0;
         mask_q  <= '0;
         en_q    <= 1'b0;
         Inr     <= '0;
      end else begin
         state_q <= state_d;
         irq_q   <= Irq_req;
         Pending <= pending_d;
         en_q    <= Int_En;
         if (Mask_we)  mask_q <= Mask_wdata;
         if (load_inr) Inr    <= enc_idx;
      end
   end

   assign Inr_Check  = (state_q == REQ);
   assign Busy       = (state_q != IDLE);
   assign Inr_Vector = VEC_BASE + N'(Inr) * VEC_STRIDE;

endmodule
